// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop synchronized input, mid-bit sampling,
// one-entry output register with read acknowledge, frame-error and overrun pulses.
module uart_rx #(
  parameter int BAUDRATE = 115200,
  parameter int FREQ     = 200_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rdreq,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int T  = FREQ / BAUDRATE;
  localparam int H  = T / 2;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] T_LAST = CW'(T - 1);
  localparam logic [CW-1:0] H_LAST = CW'(H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic          sync1_r, rxs_r, rxs_d_r;
  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic [7:0]    rdata_r, rdata_s;
  logic          rvalid_r, rvalid_s;
  logic          fe_r, fe_s;
  logic          ovr_r, ovr_s;
  logic          busy_r;

  // Synchronizer plus one-cycle delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_r <= 1'b1;
      rxs_r   <= 1'b1;
      rxs_d_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      rxs_r   <= sync1_r;
      rxs_d_r <= rxs_r;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r  <= IDLE;
      cnt_r    <= {CW{1'b0}};
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      rdata_r  <= 8'h00;
      rvalid_r <= 1'b0;
      fe_r     <= 1'b0;
      ovr_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      rdata_r  <= rdata_s;
      rvalid_r <= rvalid_s;
      fe_r     <= fe_s;
      ovr_r    <= ovr_s;
      busy_r   <= (state_s != IDLE);
    end
  end

  // Next-state and datapath logic; a completing byte takes priority over a read ack.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    rdata_s = rdata_r;
    fe_s    = 1'b0;
    ovr_s   = 1'b0;
    if (rdreq && rvalid_r) begin
      rvalid_s = 1'b0;
    end else begin
      rvalid_s = rvalid_r;
    end

    case (state_r)
      IDLE: begin
        if (rxs_d_r && !rxs_r) begin
          state_s = START;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == H_LAST) begin
          cnt_s = {CW{1'b0}};
          if (rxs_r) begin
            state_s = IDLE;
          end else begin
            state_s = DATA;
            bit_s   = 3'd0;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DATA: begin
        if (cnt_r == T_LAST) begin
          cnt_s          = {CW{1'b0}};
          shift_s[bit_r] = rxs_r;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STOP: begin
        if (cnt_r == T_LAST) begin
          cnt_s   = {CW{1'b0}};
          state_s = IDLE;
          if (rxs_r) begin
            rdata_s  = shift_r;
            rvalid_s = 1'b1;
            ovr_s    = rvalid_r && !rdreq;
          end else begin
            fe_s = 1'b1;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  assign rdata     = rdata_r;
  assign rvalid    = rvalid_r;
  assign frame_err = fe_r;
  assign overrun   = ovr_r;
  assign busy      = busy_r;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUDRATE, default 115200, serial bit rate in bits/s.
REQ-002 Parameter FREQ, default 200_000_000, clk frequency in Hz.
REQ-003 Derived constants: T = FREQ / BAUDRATE (integer division) clocks per bit; H = T / 2 clocks per half-bit.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 nrst  input  1  asynchronous active-low reset.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 rdreq  input  1  consumer acknowledge; one cycle high clears rvalid.
REQ-008 rdata  output  8  last correctly received byte.
REQ-009 rvalid  output  1  rdata holds an unread byte.
REQ-010 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse; new byte overwrote an unread byte.
REQ-012 busy  output  1  high whenever the state machine is not in IDLE.

Function
REQ-013 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-014 rx passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value rxs and its 1-cycle delayed copy.
REQ-015 States: IDLE, START, DATA, STOP; a clock counter (0..T-1) and a bit index (0..7).
REQ-016 IDLE: falling edge on rxs (delayed 1, current 0) -> START, counter cleared to 0; otherwise stay.
REQ-017 START: at counter == H-1 sample rxs; 1 -> IDLE (glitch, no outputs change); 0 -> DATA, counter 0, bit index 0.
REQ-018 DATA: at each counter == T-1 sample rxs into shift register bit [bit index], counter wraps to 0; after bit index 7 sampled -> STOP.
REQ-019 STOP: at counter == T-1 sample rxs, then -> IDLE on the same edge (mid stop bit), enabling back-to-back frames.
REQ-020 Stop sample 1: rdata <= shift register and rvalid <= 1 on that edge.
REQ-021 Stop sample 0: frame_err high for exactly the next cycle; rdata and rvalid unchanged; the byte is discarded.
REQ-022 After a frame error with rx held low, no new frame starts until rxs returns high and falls again.
REQ-023 rdreq with rvalid 1: rvalid 0 on the next edge; rdreq with rvalid 0 is ignored.
REQ-024 Byte completes while rvalid 1 and rdreq 0: rdata overwritten, rvalid stays 1, overrun pulses one cycle.
REQ-025 Byte completes in the same cycle as rdreq with rvalid 1: new byte loaded, rvalid stays 1, no overrun.
REQ-026 Latency: rvalid rises 2 + H + 9*T clocks (+/-2) after the rx pin falling edge of the start bit.
REQ-027 Counter width >= clog2(T); counters never exceed T-1.
REQ-028 frame_err and overrun are never high for two consecutive cycles from a single event.

Reset
REQ-029 nrst low, at any time including mid-frame: state IDLE, counters 0, shift register 0, rdata 8'h00, rvalid 0, frame_err 0, overrun 0, busy 0, synchronizer flops 1.
REQ-030 After nrst releases, the first frame is accepted only on a fresh rxs falling edge; a partial frame in progress is never completed.

Verification (FREQ=200_000_000, BAUDRATE=115200, T=1736, H=868)
REQ-031 Assert nrst low with rx toggling -> rdata 8'h00, rvalid 0, busy 0, frame_err 0, overrun 0 throughout.
REQ-032 Send frame 0xA5 -> rvalid 1 with rdata 8'hA5 at 2+868+15624 clocks (+/-2) after the start edge; held until a one-cycle rdreq, low on the next cycle.
REQ-033 Drive rx low 400 clocks then high -> busy high ~868 clocks then 0; rvalid and frame_err stay 0.
REQ-034 Send 0x3C with stop bit 0 -> frame_err single-cycle pulse, rvalid stays 0, rdata unchanged (8'h00 after reset).
REQ-035 Send 0x11 then 0x22 back-to-back, no rdreq -> rvalid 1, rdata 8'h22, one overrun pulse; repeat with rdreq coinciding with second completion -> no overrun.
REQ-036 Pulse nrst low during DATA of 0xFF, then send 0x5A -> outputs reset, no byte from the aborted frame, rdata 8'h5A received correctly.
